// File: rtl/dpll_branch_ctrl.sv
// DPLL decision/backtrack controller: runs the simplification kernel, pushes heuristic branch literals,
// propagates them and backtracks chronologically; kernel and heuristic handshakes may stall it indefinitely.
package dpll_pkg;
  localparam int LW = 8;
  localparam int NC = 4;
  localparam int NL = 3;

  typedef logic [LW-1:0] lit_t;
  typedef struct packed {
    logic             vld;
    lit_t [NL-1:0]    lits;
  } clause_t;
  typedef clause_t [NC-1:0] formula_t;

  localparam lit_t     zero_lit     = '0;
  localparam formula_t zero_formula = '0;

  function automatic lit_t neg_lit(input lit_t l);
    return {~l[LW-1], l[LW-2:0]};
  endfunction
endpackage

// Assigns one literal: satisfied clauses are dropped, the opposite literal is erased elsewhere.
// Result, flags and ended are registered one cycle after find.
module propagate_literal
  import dpll_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     find,
  input  lit_t     in_lit,
  input  formula_t in_formula,
  output logic     ended,
  output logic     empty_formula,
  output logic     empty_clause,
  output formula_t out_formula
);
  formula_t f_d;
  logic     ef_d, ec_d;
  logic     ended_q, ef_q, ec_q;
  formula_t f_q;

  function automatic logic has_lit(input clause_t cl, input lit_t l);
    logic hit;
    hit = 1'b0;
    for (int s = 0; s < NL; s++) begin
      if (cl.lits[s] == l) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic clause_t strip(input clause_t cl, input lit_t l);
    clause_t r;
    r = cl;
    for (int s = 0; s < NL; s++) begin
      if (cl.lits[s] == l) r.lits[s] = zero_lit;
    end
    return r;
  endfunction

  always_comb begin
    f_d  = in_formula;
    ef_d = 1'b1;
    ec_d = 1'b0;
    for (int c = 0; c < NC; c++) begin
      if (in_formula[c].vld) begin
        if (has_lit(in_formula[c], in_lit)) f_d[c].vld = 1'b0;
        else                                f_d[c] = strip(in_formula[c], neg_lit(in_lit));
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (f_d[c].vld) begin
        ef_d = 1'b0;
        if (f_d[c].lits == '0) ec_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ended_q <= 1'b0;
      ef_q    <= 1'b0;
      ec_q    <= 1'b0;
      f_q     <= zero_formula;
    end else begin
      ended_q <= find;
      if (find) begin
        ef_q <= ef_d;
        ec_q <= ec_d;
        f_q  <= f_d;
      end
    end
  end

  assign ended         = ended_q;
  assign empty_formula = ef_q;
  assign empty_clause  = ec_q;
  assign out_formula   = f_q;
endmodule

module dpll_branch_ctrl
  import dpll_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  formula_t      in_formula,
  output logic          done,
  output logic          sat,
  output logic          unsat,
  output logic          overflow,
  output formula_t      result_formula,
  output logic [DW-1:0] depth,
  output logic          k_find,
  output formula_t      k_formula,
  input  logic          k_ended,
  input  logic          k_sat,
  input  logic          k_unsat,
  input  formula_t      k_out_formula,
  output logic          br_req,
  output formula_t      br_formula,
  input  logic          br_ack,
  input  lit_t          br_lit
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, K_RUN, BRANCH, PROP, BACKTRACK} state_t;

  state_t        state_q;
  logic          done_q, sat_q, unsat_q, ovf_q;
  formula_t      result_q;
  logic [DW-1:0] depth_q;
  logic          k_find_q;
  formula_t      k_formula_q;
  logic          br_req_q;
  formula_t      last_q;
  logic          prop_find_q;
  lit_t          prop_lit_q;
  formula_t      prop_f_q;

  formula_t      stk_f_q    [DEPTH];
  lit_t          stk_l_q    [DEPTH];
  logic          stk_flip_q [DEPTH];

  logic          p_ended, p_ef, p_ec;
  formula_t      p_out;
  logic [AW-1:0] top_idx, push_idx;

  assign top_idx  = AW'(depth_q - DW'(1));
  assign push_idx = AW'(depth_q);

  propagate_literal u_prop (
    .clock         (clock),
    .reset         (reset),
    .find          (prop_find_q),
    .in_lit        (prop_lit_q),
    .in_formula    (prop_f_q),
    .ended         (p_ended),
    .empty_formula (p_ef),
    .empty_clause  (p_ec),
    .out_formula   (p_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      unsat_q     <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= zero_formula;
      depth_q     <= '0;
      k_find_q    <= 1'b0;
      k_formula_q <= zero_formula;
      br_req_q    <= 1'b0;
      last_q      <= zero_formula;
      prop_find_q <= 1'b0;
      prop_lit_q  <= zero_lit;
      prop_f_q    <= zero_formula;
      for (int i = 0; i < DEPTH; i++) begin
        stk_f_q[i]    <= zero_formula;
        stk_l_q[i]    <= zero_lit;
        stk_flip_q[i] <= 1'b0;
      end
    end else begin
      done_q      <= 1'b0;
      k_find_q    <= 1'b0;
      prop_find_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            k_formula_q <= in_formula;
            sat_q       <= 1'b0;
            unsat_q     <= 1'b0;
            ovf_q       <= 1'b0;
            depth_q     <= '0;
            k_find_q    <= 1'b1;
            state_q     <= K_RUN;
          end
        end
        K_RUN: begin
          if (k_ended) begin
            last_q <= k_out_formula;
            if (k_sat) begin
              done_q   <= 1'b1;
              sat_q    <= 1'b1;
              result_q <= k_out_formula;
              state_q  <= IDLE;
            end else if (k_unsat) begin
              state_q <= BACKTRACK;
            end else if (depth_q == DW'(DEPTH)) begin
              // Stack full: give up before ever asking the heuristic.
              done_q   <= 1'b1;
              ovf_q    <= 1'b1;
              result_q <= k_out_formula;
              state_q  <= IDLE;
            end else begin
              br_req_q <= 1'b1;
              state_q  <= BRANCH;
            end
          end
        end
        BRANCH: begin
          if (br_ack) begin
            br_req_q <= 1'b0;
            if (br_lit == zero_lit) begin
              done_q   <= 1'b1;
              result_q <= last_q;
              state_q  <= IDLE;
            end else begin
              stk_f_q[push_idx]    <= last_q;
              stk_l_q[push_idx]    <= br_lit;
              stk_flip_q[push_idx] <= 1'b0;
              depth_q              <= depth_q + DW'(1);
              prop_find_q          <= 1'b1;
              prop_lit_q           <= br_lit;
              prop_f_q             <= last_q;
              state_q              <= PROP;
            end
          end
        end
        PROP: begin
          if (p_ended) begin
            last_q <= p_out;
            if (p_ef) begin
              done_q   <= 1'b1;
              sat_q    <= 1'b1;
              result_q <= p_out;
              state_q  <= IDLE;
            end else if (p_ec) begin
              state_q <= BACKTRACK;
            end else begin
              k_formula_q <= p_out;
              k_find_q    <= 1'b1;
              state_q     <= K_RUN;
            end
          end
        end
        BACKTRACK: begin
          if (depth_q == '0) begin
            done_q   <= 1'b1;
            unsat_q  <= 1'b1;
            result_q <= last_q;
            state_q  <= IDLE;
          end else if (stk_flip_q[top_idx]) begin
            depth_q <= depth_q - DW'(1);
          end else begin
            // Second polarity is tried on the formula saved when the decision was made.
            stk_flip_q[top_idx] <= 1'b1;
            prop_find_q         <= 1'b1;
            prop_lit_q          <= neg_lit(stk_l_q[top_idx]);
            prop_f_q            <= stk_f_q[top_idx];
            state_q             <= PROP;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done           = done_q;
  assign sat            = sat_q;
  assign unsat          = unsat_q;
  assign overflow       = ovf_q;
  assign result_formula = result_q;
  assign depth          = depth_q;
  assign k_find         = k_find_q;
  assign k_formula      = k_formula_q;
  assign br_req         = br_req_q;
  assign br_formula     = last_q;
endmodule

// File: tb/tb_dpll_branch_ctrl.sv
// Bench for dpll_branch_ctrl with DEPTH=2: mock kernel and heuristic, directed scenarios plus
// random two-variable formulas checked against a brute-force satisfiability model.
module tb_dpll_branch_ctrl;
  import dpll_pkg::*;

  localparam int DEPTH = 2;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  formula_t      in_formula = '0;
  logic          done, sat, unsat, overflow;
  formula_t      result_formula;
  logic [DW-1:0] depth;
  logic          k_find;
  formula_t      k_formula;
  logic          k_ended = 1'b0, k_sat = 1'b0, k_unsat = 1'b0;
  formula_t      k_out_formula = '0;
  logic          br_req;
  formula_t      br_formula;
  logic          br_ack = 1'b0;
  lit_t          br_lit = '0;

  int n_checks = 0;
  int n_errors = 0;

  int   km_mode = 1;
  bit   km_sat = 1'b0, km_unsat = 1'b0;
  int   km_lat = 1;
  bit   hm_random = 1'b0;
  lit_t hm_q[$];

  int   kf_cnt, br_cnt, done_cnt, max_depth;
  bit   br_prev = 1'b0;
  lit_t prop_lits[$];

  dpll_branch_ctrl #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .in_formula(in_formula),
    .done(done), .sat(sat), .unsat(unsat), .overflow(overflow),
    .result_formula(result_formula), .depth(depth),
    .k_find(k_find), .k_formula(k_formula), .k_ended(k_ended), .k_sat(k_sat),
    .k_unsat(k_unsat), .k_out_formula(k_out_formula),
    .br_req(br_req), .br_formula(br_formula), .br_ack(br_ack), .br_lit(br_lit)
  );

  always #5 clock = ~clock;

  function automatic bit no_clauses(input formula_t f);
    for (int c = 0; c < NC; c++) if (f[c].vld) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit has_empty_clause(input formula_t f);
    for (int c = 0; c < NC; c++) if (f[c].vld && f[c].lits == '0) return 1'b1;
    return 1'b0;
  endfunction

  // Satisfiability over variables 1 and 2 by trying all four assignments.
  function automatic bit m_satisfiable(input formula_t f);
    bit all_ok, any_true, val;
    lit_t l;
    for (int a = 0; a < 4; a++) begin
      all_ok = 1'b1;
      for (int c = 0; c < NC; c++) begin
        if (f[c].vld) begin
          any_true = 1'b0;
          for (int s = 0; s < NL; s++) begin
            l = f[c].lits[s];
            if (l != '0) begin
              val = (l[6:0] == 7'd1) ? a[0] : a[1];
              if (val != l[7]) any_true = 1'b1;
            end
          end
          if (!any_true) all_ok = 1'b0;
        end
      end
      if (all_ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic formula_t rand_formula();
    formula_t f;
    f = '0;
    for (int c = 0; c < NC; c++) begin
      f[c].vld = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NL; s++)
        if ($urandom_range(0, 2) != 0)
          f[c].lits[s] = {1'($urandom_range(0, 1)), 7'($urandom_range(1, 2))};
    end
    return f;
  endfunction

  function automatic lit_t pick_lit(input formula_t f);
    lit_t cand[$];
    for (int c = 0; c < NC; c++)
      if (f[c].vld)
        for (int s = 0; s < NL; s++)
          if (f[c].lits[s] != '0) cand.push_back(f[c].lits[s]);
    if (cand.size() == 0) return '0;
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  // Mock kernel: echoes its input formula, flags either scripted or derived from the formula.
  always begin
    @(posedge clock); #1;
    if (k_find && !reset) begin
      repeat (km_lat) @(posedge clock);
      #1;
      k_out_formula = k_formula;
      k_sat   = (km_mode == 0) ? no_clauses(k_formula)       : km_sat;
      k_unsat = (km_mode == 0) ? has_empty_clause(k_formula) : km_unsat;
      k_ended = 1'b1;
      @(posedge clock); #1;
      k_ended = 1'b0;
      k_sat   = 1'b0;
      k_unsat = 1'b0;
    end
  end

  // Mock heuristic: random literal of the offered formula, or next scripted literal; silent when none.
  always begin
    bit   ok;
    lit_t l;
    @(posedge clock); #1;
    if (br_req && !reset) begin
      ok = 1'b0;
      l  = '0;
      if (hm_random) begin
        ok = 1'b1;
        l  = pick_lit(br_formula);
      end else if (hm_q.size() != 0) begin
        ok = 1'b1;
        l  = hm_q.pop_front();
      end
      if (ok) begin
        br_ack = 1'b1;
        br_lit = l;
        @(posedge clock); #1;
        br_ack = 1'b0;
        br_lit = '0;
      end
    end
  end

  always @(negedge clock) begin
    if (k_find) kf_cnt++;
    if (br_req && !br_prev) br_cnt++;
    br_prev = br_req;
    if (done) done_cnt++;
    if (dut.u_prop.find) prop_lits.push_back(dut.u_prop.in_lit);
    if (int'(depth) > max_depth) max_depth = int'(depth);
  end

  task automatic clear_counts();
    kf_cnt = 0; br_cnt = 0; done_cnt = 0; max_depth = 0;
    prop_lits.delete();
  endtask

  task automatic run_solve(input formula_t f, output bit to);
    clear_counts();
    @(posedge clock); #1;
    in_formula = f;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (done_cnt != 0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({done, sat, unsat, overflow, k_find, br_req} !== 6'b0) begin
      n_errors++; $display("FAIL reset_outputs: got %b want 000000", {done, sat, unsat, overflow, k_find, br_req});
    end
    n_checks++;
    if (depth !== '0) begin n_errors++; $display("FAIL reset_depth: got %0d want 0", depth); end
    n_checks++;
    if (result_formula !== zero_formula || k_formula !== zero_formula || br_formula !== zero_formula) begin
      n_errors++; $display("FAIL reset_formulas: got %h/%h/%h want 0", result_formula, k_formula, br_formula);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_kernel_sat();
    formula_t f;
    bit to;
    km_mode = 1; km_sat = 1'b1; km_unsat = 1'b1; km_lat = 2; hm_random = 1'b0; hm_q.delete();
    f = rand_formula();
    run_solve(f, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL ksat_timeout: got no done want done"); end
    n_checks++; if (done_cnt != 1 || kf_cnt != 1 || br_cnt != 0) begin
      n_errors++; $display("FAIL ksat_counts: got done=%0d kfind=%0d brreq=%0d want 1 1 0", done_cnt, kf_cnt, br_cnt);
    end
    n_checks++; if ({sat, unsat, overflow} !== 3'b100 || depth !== '0) begin
      n_errors++; $display("FAIL ksat_flags: got %b depth=%0d want 100 depth=0", {sat, unsat, overflow}, depth);
    end
    n_checks++; if (result_formula !== f) begin n_errors++; $display("FAIL ksat_result: got %h want %h", result_formula, f); end
  endtask

  task automatic test_kernel_unsat();
    bit to;
    km_mode = 1; km_sat = 1'b0; km_unsat = 1'b1; km_lat = 1;
    run_solve(rand_formula(), to);
    n_checks++; if (to) begin n_errors++; $display("FAIL kunsat_timeout: got no done want done"); end
    n_checks++; if ({sat, unsat, overflow} !== 3'b010 || depth !== '0) begin
      n_errors++; $display("FAIL kunsat_flags: got %b depth=%0d want 010 depth=0", {sat, unsat, overflow}, depth);
    end
    n_checks++; if (done_cnt != 1 || br_cnt != 0) begin
      n_errors++; $display("FAIL kunsat_counts: got done=%0d brreq=%0d want 1 0", done_cnt, br_cnt);
    end
  endtask

  task automatic test_branch_sat();
    formula_t f, exp;
    bit to;
    km_mode = 1; km_sat = 1'b0; km_unsat = 1'b0; km_lat = 3;
    hm_q.delete(); hm_q.push_back(8'h03);
    f = '0; f[0].vld = 1'b1; f[0].lits[0] = 8'h03;
    exp = f; exp[0].vld = 1'b0;
    run_solve(f, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL brsat_timeout: got no done want done"); end
    n_checks++; if ({sat, unsat, overflow} !== 3'b100 || depth !== 2'd1) begin
      n_errors++; $display("FAIL brsat_flags: got %b depth=%0d want 100 depth=1", {sat, unsat, overflow}, depth);
    end
    n_checks++; if (result_formula !== exp) begin n_errors++; $display("FAIL brsat_result: got %h want %h", result_formula, exp); end
    n_checks++; if (prop_lits.size() != 1 || br_cnt != 1) begin
      n_errors++; $display("FAIL brsat_counts: got props=%0d brreq=%0d want 1 1", prop_lits.size(), br_cnt);
    end
  endtask

  task automatic test_flip_sat();
    formula_t f, exp;
    bit to;
    km_mode = 1; km_sat = 1'b0; km_unsat = 1'b0; km_lat = 1;
    hm_q.delete(); hm_q.push_back(8'h03);
    f = '0; f[0].vld = 1'b1; f[0].lits[1] = 8'h83;
    exp = f; exp[0].vld = 1'b0;
    run_solve(f, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL flip_timeout: got no done want done"); end
    n_checks++; if ({sat, unsat, overflow} !== 3'b100 || depth !== 2'd1) begin
      n_errors++; $display("FAIL flip_flags: got %b depth=%0d want 100 depth=1", {sat, unsat, overflow}, depth);
    end
    n_checks++; if (dut.stk_flip_q[0] !== 1'b1) begin n_errors++; $display("FAIL flip_bit: got %b want 1", dut.stk_flip_q[0]); end
    n_checks++; if (prop_lits.size() != 2) begin
      n_errors++; $display("FAIL flip_nprops: got %0d want 2", prop_lits.size());
    end else if (prop_lits[0] !== 8'h03 || prop_lits[1] !== 8'h83) begin
      n_errors++; $display("FAIL flip_lits: got %h %h want 03 83", prop_lits[0], prop_lits[1]);
    end
    n_checks++; if (result_formula !== exp || kf_cnt != 1) begin
      n_errors++; $display("FAIL flip_result: got %h kfind=%0d want %h kfind=1", result_formula, kf_cnt, exp);
    end
  endtask

  task automatic test_backtrack_unsat();
    formula_t f;
    lit_t want[4];
    bit to;
    km_mode = 1; km_sat = 1'b0; km_unsat = 1'b0; km_lat = 2;
    hm_q.delete(); hm_q.push_back(8'h01); hm_q.push_back(8'h02);
    f = '0;
    f[0].vld = 1'b1; f[0].lits[0] = 8'h81;
    f[1].vld = 1'b1; f[1].lits[2] = 8'h02;
    f[2].vld = 1'b1; f[2].lits[1] = 8'h82;
    want[0] = 8'h01; want[1] = 8'h81; want[2] = 8'h02; want[3] = 8'h82;
    run_solve(f, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL bt_timeout: got no done want done"); end
    n_checks++; if ({sat, unsat, overflow} !== 3'b010 || depth !== '0 || max_depth != 2) begin
      n_errors++; $display("FAIL bt_flags: got %b depth=%0d max=%0d want 010 depth=0 max=2", {sat, unsat, overflow}, depth, max_depth);
    end
    n_checks++; if (prop_lits.size() != 4) begin
      n_errors++; $display("FAIL bt_nprops: got %0d want 4", prop_lits.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (prop_lits[i] !== want[i]) begin
          n_errors++; $display("FAIL bt_lit%0d: got %h want %h", i, prop_lits[i], want[i]);
        end
    end
    n_checks++; if (br_cnt != 2 || kf_cnt != 2 || done_cnt != 1) begin
      n_errors++; $display("FAIL bt_counts: got brreq=%0d kfind=%0d done=%0d want 2 2 1", br_cnt, kf_cnt, done_cnt);
    end
  endtask

  task automatic test_overflow();
    formula_t f, exp;
    bit to;
    km_mode = 1; km_sat = 1'b0; km_unsat = 1'b0; km_lat = 1;
    hm_q.delete(); hm_q.push_back(8'h01); hm_q.push_back(8'h02);
    f = '0;
    f[0].vld = 1'b1; f[0].lits[0] = 8'h01;
    f[1].vld = 1'b1; f[1].lits[0] = 8'h02;
    f[2].vld = 1'b1; f[2].lits[0] = 8'h05;
    exp = f; exp[0].vld = 1'b0; exp[1].vld = 1'b0;
    run_solve(f, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL ovf_timeout: got no done want done"); end
    n_checks++; if ({sat, unsat, overflow} !== 3'b001 || depth !== 2'd2) begin
      n_errors++; $display("FAIL ovf_flags: got %b depth=%0d want 001 depth=2", {sat, unsat, overflow}, depth);
    end
    n_checks++; if (br_cnt != 2 || kf_cnt != 3) begin
      n_errors++; $display("FAIL ovf_counts: got brreq=%0d kfind=%0d want 2 3", br_cnt, kf_cnt);
    end
    n_checks++; if (result_formula !== exp) begin n_errors++; $display("FAIL ovf_result: got %h want %h", result_formula, exp); end
  endtask

  task automatic test_indeterminate();
    formula_t f;
    bit to;
    km_mode = 1; km_sat = 1'b0; km_unsat = 1'b0; km_lat = 1;
    hm_q.delete(); hm_q.push_back(8'h00);
    f = rand_formula();
    run_solve(f, to);
    n_checks++; if (to) begin n_errors++; $display("FAIL indet_timeout: got no done want done"); end
    n_checks++; if ({sat, unsat, overflow} !== 3'b000 || depth !== '0 || done_cnt != 1) begin
      n_errors++; $display("FAIL indet_flags: got %b depth=%0d done=%0d want 000 0 1", {sat, unsat, overflow}, depth, done_cnt);
    end
    n_checks++; if (result_formula !== f) begin n_errors++; $display("FAIL indet_result: got %h want %h", result_formula, f); end
  endtask

  task automatic test_reset_mid();
    formula_t f, f2, exp;
    bit seen, to;
    km_mode = 1; km_sat = 1'b0; km_unsat = 1'b0; km_lat = 1;
    hm_q.delete(); hm_q.push_back(8'h01);
    f = '0;
    f[0].vld = 1'b1; f[0].lits[0] = 8'h01;
    f[1].vld = 1'b1; f[1].lits[0] = 8'h02;
    exp = f; exp[0].vld = 1'b0;
    clear_counts();
    @(posedge clock); #1; in_formula = f; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (br_req && depth == 2'd1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL mid_wait: got no second br_req want br_req at depth 1"); end
    f2 = rand_formula();
    @(posedge clock); #1; in_formula = f2; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    n_checks++; if (k_formula !== exp || br_req !== 1'b1) begin
      n_errors++; $display("FAIL mid_busy_start: got %h br_req=%b want %h br_req=1", k_formula, br_req, exp);
    end
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (br_req !== 1'b0 || depth !== '0 || k_find !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset: got br_req=%b depth=%0d k_find=%b want 0 0 0", br_req, depth, k_find);
    end
    reset = 1'b0;
    repeat (6) @(negedge clock);
    n_checks++; if (done_cnt != 0) begin n_errors++; $display("FAIL mid_nodone: got %0d want 0", done_cnt); end
    km_sat = 1'b1;
    run_solve(f2, to);
    n_checks++; if (to || {sat, unsat, overflow} !== 3'b100 || done_cnt != 1 || kf_cnt != 1) begin
      n_errors++; $display("FAIL mid_restart: got to=%b flags=%b done=%0d kfind=%0d want 0 100 1 1", to, {sat, unsat, overflow}, done_cnt, kf_cnt);
    end
  endtask

  task automatic test_random();
    km_mode = 0; hm_random = 1'b1; hm_q.delete();
    for (int it = 0; it < 40; it++) begin
      formula_t f;
      logic [NC-1:0] vlds;
      bit exp, to;
      f = rand_formula();
      exp = m_satisfiable(f);
      km_lat = $urandom_range(1, 3);
      run_solve(f, to);
      n_checks++; if (to) begin n_errors++; $display("FAIL rnd%0d_timeout: got no done want done", it); end
      n_checks++; if ({sat, unsat, overflow} !== {exp, ~exp, 1'b0}) begin
        n_errors++; $display("FAIL rnd%0d_flags: got %b want %b formula %h", it, {sat, unsat, overflow}, {exp, ~exp, 1'b0}, f);
      end
      n_checks++; if (done_cnt != 1 || max_depth > DEPTH) begin
        n_errors++; $display("FAIL rnd%0d_bounds: got done=%0d maxdepth=%0d want 1 <=%0d", it, done_cnt, max_depth, DEPTH);
      end
      for (int c = 0; c < NC; c++) vlds[c] = result_formula[c].vld;
      if (exp) begin
        n_checks++; if (vlds !== '0) begin n_errors++; $display("FAIL rnd%0d_result: got clause valids %b want 0", it, vlds); end
      end
    end
    hm_random = 1'b0;
  endtask

  initial begin
    test_reset();
    test_kernel_sat();
    test_kernel_unsat();
    test_branch_sat();
    test_flip_sat();
    test_backtrack_unsat();
    test_overflow();
    test_indeterminate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
